dht11_request_controller: RTL

- Sequences DHT11 measurements on behalf of the host command path, one request at a time.
- Drives the sensor communication block's enable_sensor, waits for its done/erro, validates the 40-bit frame checksum, and returns a 16-bit result with a status code over a valid/ready response channel.
- Enforces the sensor's minimum interval between measurements and guards against a sensor block that never reports done.
- Sits between the host command decoder (upstream) and the DHT11 communication block (downstream).

---
 rtl/dht11_request_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dht11_request_controller.sv
// rtl/dht11_request_controller.sv - DHT11 measurement sequencer with holdoff, timeout and checksum check
// One request at a time; results and status codes leave over a valid/ready response channel.
module dht11_request_controller #(
  parameter int unsigned MIN_INTERVAL_CYCLES = 100000000,
  parameter int unsigned TIMEOUT_CYCLES      = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  output logic        enable_sensor,
  input  logic [39:0] dados_sensor,
  input  logic        erro,
  input  logic        done,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_code
);

  localparam int unsigned MAX_CYCLES = (MIN_INTERVAL_CYCLES > TIMEOUT_CYCLES) ?
                                       MIN_INTERVAL_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_INTERVAL_CYCLES);
  localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {IDLE, HOLDOFF, START, WAIT_DONE, CHECK, RESPOND} state_t;

  state_t         state_q, state_d;
  logic           done_m, done_s, erro_m, erro_s;
  logic [1:0]     cmd_q;
  logic [39:0]    frame_q;
  logic           err_q;
  logic [CW-1:0]  hold_cnt, to_cnt;
  logic [1:0]     last_code;
  logic           req_ready_q, enable_q, resp_valid_q;
  logic [15:0]    resp_data_q;
  logic [1:0]     resp_code_q;

  logic           req_hs, status_hs, meas_fin, en_d;
  logic [1:0]     meas_code;
  logic [7:0]     sum8;
  logic [15:0]    payload;

  assign req_ready     = req_ready_q;
  assign enable_sensor = enable_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_code     = resp_code_q;

  always_comb begin
    state_d   = state_q;
    req_hs    = (state_q == IDLE) && req_valid && req_ready_q;
    status_hs = 1'b0;
    meas_fin  = 1'b0;
    meas_code = 2'b00;
    sum8      = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    payload   = 16'h0000;
    case (cmd_q)
      2'b00:   payload = frame_q[39:24];
      2'b01:   payload = frame_q[23:8];
      2'b10:   payload = {frame_q[39:32], frame_q[23:16]};
      default: payload = 16'h0000;
    endcase
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          status_hs = (req_cmd == 2'b11);
          state_d   = status_hs ? RESPOND : HOLDOFF;
        end
      end
      HOLDOFF: if (hold_cnt == '0) state_d = START;
      START:   state_d = WAIT_DONE;
      WAIT_DONE: begin
        // done has priority over a timeout expiring on the same cycle
        if (done_s) begin
          state_d = CHECK;
        end else if (to_cnt <= ONE) begin
          state_d   = RESPOND;
          meas_fin  = 1'b1;
          meas_code = 2'b11;
        end
      end
      CHECK: begin
        state_d  = RESPOND;
        meas_fin = 1'b1;
        if (err_q)                     meas_code = 2'b01;
        else if (frame_q[7:0] != sum8) meas_code = 2'b10;
        else                           meas_code = 2'b00;
      end
      RESPOND: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    en_d = (state_d == START) || (state_d == WAIT_DONE) || (state_d == CHECK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      done_m       <= 1'b0;
      done_s       <= 1'b0;
      erro_m       <= 1'b0;
      erro_s       <= 1'b0;
      cmd_q        <= 2'b00;
      frame_q      <= '0;
      err_q        <= 1'b0;
      hold_cnt     <= HOLD_LOAD;
      to_cnt       <= '0;
      last_code    <= 2'b00;
      req_ready_q  <= 1'b0;
      enable_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      done_m      <= done;
      done_s      <= done_m;
      erro_m      <= erro;
      erro_s      <= erro_m;
      req_ready_q <= (state_d == IDLE);
      enable_q    <= en_d;

      if (enable_q && !en_d)              hold_cnt <= HOLD_LOAD;
      else if (!enable_q && hold_cnt != '0) hold_cnt <= hold_cnt - ONE;

      if (state_q == START)                        to_cnt <= TO_LOAD;
      else if (state_q == WAIT_DONE && to_cnt != '0) to_cnt <= to_cnt - ONE;

      // the frame is only trustworthy while done is seen high
      if (state_q == WAIT_DONE && done_s) begin
        frame_q <= dados_sensor;
        err_q   <= erro_s;
      end

      if (req_hs) cmd_q <= req_cmd;

      if (status_hs) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= {14'b0, last_code};
        resp_code_q  <= 2'b00;
      end else if (meas_fin) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= (meas_code == 2'b00) ? payload : 16'h0000;
        resp_code_q  <= meas_code;
        last_code    <= meas_code;
      end else if (state_q == RESPOND && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

endmodule
